fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of Hunter_RV32: owns the PC register, issues one
//  request at a time on a valid/ready instruction-memory port, and presents
//  each fetched instruction with its PC to decode on a valid/ready handshake.
//  Redirects from branch/jump resolution take priority; fetches already in flight are squashed.
//  The next-PC choice (pc+4 vs redirect_pc) is a 2:1 selection driven by redirect_valid.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value after reset; bits [1:0] are forced to 0
//  NOP_INST  32'h0000_0013  value of if_inst while if_valid=0 (addi x0,x0,0)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset; asynchronous, active-high
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  fetch address (word aligned)
//  imem_rsp_valid  in   1   response valid; memory returns responses in order, max 1 outstanding
//  imem_rsp_data   in   32  fetched instruction word
//  redirect_valid  in   1   redirect the PC this cycle (single-cycle pulse or level)
//  redirect_pc     in   32  redirect target; bits [1:0] ignored
//  if_valid        out  1   instruction valid to decode
//  if_ready        in   1   decode accepts instruction
//  if_pc           out  32  PC of if_inst
//  if_inst         out  32  instruction word
// BEHAVIOUR
//  Reset (async, rst=1): pc=RESET_PC, state=REQ, if_valid=0, if_pc=0,
//   if_inst=NOP_INST. imem_req_valid=0 while rst is high.
//  All outputs are registered except imem_req_valid/imem_req_addr, which are decoded from state/pc.
//  States:
//   REQ : imem_req_valid=1, imem_req_addr=pc. req_ready=1 -> WAIT.
//   WAIT: await rsp. rsp_valid=1 -> if_inst<=rsp_data, if_pc<=pc,
//         if_valid<=1, pc<=pc+4, -> HOLD.
//   HOLD: if_valid=1, if_pc/if_inst stable. if_ready=1 -> if_valid<=0,
//         if_inst<=NOP_INST, -> REQ.
//   DROP: stale response outstanding. rsp_valid=1 -> discard data, -> REQ.
//  Redirect (redirect_valid=1) overrides the normal transition:
//   pc <= {redirect_pc[31:2],2'b00} in every state (latest redirect wins).
//   REQ,  req_ready=0 -> stay REQ; the address changes next cycle (memory tolerates retraction).
//   REQ,  req_ready=1 -> DROP (the accepted request is stale).
//   WAIT, rsp_valid=0 -> DROP.   WAIT, rsp_valid=1 -> discard rsp, -> REQ.
//   HOLD -> if_valid<=0 (squash, even if if_ready=1 this cycle), -> REQ.
//   DROP -> stay DROP; rsp_valid=1 same cycle -> discard, -> REQ.
//  Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
//  Throughput: the minimum is 3 cycles per instruction (REQ, WAIT, HOLD) with
//   zero-wait memory and if_ready=1. No instruction is ever duplicated or skipped
//   except through a redirect.
//  if_pc/if_inst hold their values while if_valid=1 and if_ready=0.
//  rst asserted mid-operation: immediate return to reset values. An outstanding
//   memory response arriving after rst deasserts is not tracked (memory is reset together with this block).
// TESTING
//  1. Reset, RESET_PC=0, zero-wait mem, if_ready=1 -> if_pc 0,4,8 with matching
//     words; one instruction every 3 cycles; req_valid=0 during rst.
//  2. if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc, if_inst stable;
//     no new imem request until the cycle after if_ready=1.
//  3. Redirect to 32'h100 while in WAIT, rsp 2 cycles later -> response dropped,
//     next request addr 32'h100, next if_pc=32'h100.
//  4. Redirect to 32'h203 in HOLD with if_ready=1 same cycle -> instruction not
//     consumed (if_valid falls), next req addr 32'h200.
//  5. Redirect to 32'hFFFF_FFFC -> if_pc FFFF_FFFC then 0000_0000.
//  6. Assert rst asynchronously while in DROP -> outputs hit reset values before
//     next clk edge; first req after release addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// hands each fetched word with its PC to decode over a valid/ready handshake.
// Redirects override the normal flow; in-flight fetches are squashed.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            if_valid_nxt;
  logic [XLEN-1:0] if_pc_nxt, if_inst_nxt;
  logic [XLEN-1:0] redir_pc;

  // Redirect target with the byte-offset bits cleared
  assign redir_pc = redirect_pc & ALIGN_MASK;

  // Request port is decoded straight from state/pc; held low during reset
  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_req_addr  = pc;

  // State, PC and decode-facing output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= PC_INIT;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= NOP_INST;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      if_valid <= if_valid_nxt;
      if_pc    <= if_pc_nxt;
      if_inst  <= if_inst_nxt;
    end
  end

  // Next-state and next-output selection; a redirect preempts the normal path
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    if_valid_nxt = if_valid;
    if_pc_nxt    = if_pc;
    if_inst_nxt  = if_inst;

    unique case (state)
      S_REQ: begin
        if (redirect_valid) begin
          // an accepted request is now stale and its response must be dropped
          state_nxt = imem_req_ready ? S_DROP : S_REQ;
        end else if (imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          if_valid_nxt = 1'b1;
          if_pc_nxt    = pc;
          if_inst_nxt  = imem_rsp_data;
          pc_nxt       = pc + PC_STEP;
          state_nxt    = S_HOLD;
        end
      end
      S_HOLD: begin
        // squash on redirect even if decode is accepting this cycle
        if (redirect_valid || if_ready) begin
          if_valid_nxt = 1'b0;
          if_inst_nxt  = NOP_INST;
          state_nxt    = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase

    // latest redirect always wins the PC
    if (redirect_valid) begin
      pc_nxt = redir_pc;
    end
  end

endmodule
